// File: rtl/match_controller.sv
// Two-player match sequencer: serve countdown, scoring with optional win-by-two,
// pause/resume and win detection. All outputs are registered.
module match_controller #(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int WIN_BY_TWO  = 0,
  parameter int SERVE_DELAY = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1ms,
  input  logic               start,
  input  logic               pause,
  input  logic               goal_p1,
  input  logic               goal_p2,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [2:0]         game_state,
  output logic               serve_side,
  output logic               ball_en
);

  localparam int CNT_W = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);
  localparam logic [CNT_W-1:0]   DELAY_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] MAX_SCORE  = '1;
  localparam logic [SCORE_W:0]   WIN_W      = (SCORE_W + 1)'(WIN_SCORE);
  localparam logic [SCORE_W:0]   LEAD_W     = (SCORE_W + 1)'(2);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    SERVE  = 3'b001,
    PLAY   = 3'b010,
    PAUSE  = 3'b011,
    P1_WIN = 3'b100,
    P2_WIN = 3'b101
  } state_t;

  state_t             state, state_nx, from, from_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [SCORE_W-1:0] p1_nx, p2_nx;
  logic               side_nx;

  logic [SCORE_W:0]   p1_inc, p2_inc;
  logic               p1_sat, p2_sat;
  logic [SCORE_W-1:0] p1_new, p2_new;
  logic               p1_wins, p2_wins;

  // Win check looks at the post-increment score so WIN and final score land together.
  always_comb begin
    p1_inc = {1'b0, p1_score} + 1'b1;
    p2_inc = {1'b0, p2_score} + 1'b1;
    p1_sat = (p1_score == MAX_SCORE);
    p2_sat = (p2_score == MAX_SCORE);
    p1_new = p1_sat ? p1_score : p1_inc[SCORE_W-1:0];
    p2_new = p2_sat ? p2_score : p2_inc[SCORE_W-1:0];
    if (WIN_BY_TWO != 0) begin
      p1_wins = p1_sat || ((p1_inc >= WIN_W) && (p1_inc >= ({1'b0, p2_score} + LEAD_W)));
      p2_wins = p2_sat || ((p2_inc >= WIN_W) && (p2_inc >= ({1'b0, p1_score} + LEAD_W)));
    end else begin
      p1_wins = p1_sat || (p1_inc == WIN_W);
      p2_wins = p2_sat || (p2_inc == WIN_W);
    end
  end

  always_comb begin
    state_nx = state;
    from_nx  = from;
    cnt_nx   = cnt;
    p1_nx    = p1_score;
    p2_nx    = p2_score;
    side_nx  = serve_side;
    case (state)
      IDLE, P1_WIN, P2_WIN: begin
        if (start) begin
          state_nx = SERVE;
          p1_nx    = '0;
          p2_nx    = '0;
          side_nx  = 1'b0;
          cnt_nx   = '0;
        end
      end
      SERVE: begin
        if (pause) begin
          state_nx = PAUSE;
          from_nx  = SERVE;
        end else if (tick_1ms) begin
          if (cnt == DELAY_LAST) begin
            state_nx = PLAY;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      PLAY: begin
        if (pause) begin
          state_nx = PAUSE;
          from_nx  = PLAY;
        end else if (goal_p1 && goal_p2) begin
          state_nx = SERVE;
          cnt_nx   = '0;
        end else if (goal_p1) begin
          p1_nx    = p1_new;
          side_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = p1_wins ? P1_WIN : SERVE;
        end else if (goal_p2) begin
          p2_nx    = p2_new;
          side_nx  = 1'b0;
          cnt_nx   = '0;
          state_nx = p2_wins ? P2_WIN : SERVE;
        end
      end
      PAUSE: begin
        if (pause) state_nx = from;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      from       <= SERVE;
      cnt        <= '0;
      p1_score   <= '0;
      p2_score   <= '0;
      serve_side <= 1'b0;
      ball_en    <= 1'b0;
    end else begin
      state      <= state_nx;
      from       <= from_nx;
      cnt        <= cnt_nx;
      p1_score   <= p1_nx;
      p2_score   <= p2_nx;
      serve_side <= side_nx;
      ball_en    <= (state_nx == PLAY);
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: three parameterisations share one stimulus stream,
// each checked every cycle against a rule-level model, plus fixed vectors and corner sequences.
module tb_match_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0, tick_1ms = 1'b0, start = 1'b0, pause = 1'b0;
  logic goal_p1 = 1'b0, goal_p2 = 1'b0;

  logic [3:0] p1_a, p2_a, p1_b, p2_b;
  logic [2:0] p1_c, p2_c;
  logic [2:0] gs_a, gs_b, gs_c;
  logic       side_a, side_b, side_c, ball_a, ball_b, ball_c;

  match_controller #(.SCORE_W(4), .WIN_SCORE(9), .WIN_BY_TWO(0), .SERVE_DELAY(3)) dut_a (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .start(start), .pause(pause),
    .goal_p1(goal_p1), .goal_p2(goal_p2), .p1_score(p1_a), .p2_score(p2_a),
    .game_state(gs_a), .serve_side(side_a), .ball_en(ball_a));

  match_controller #(.SCORE_W(4), .WIN_SCORE(9), .WIN_BY_TWO(1), .SERVE_DELAY(5)) dut_b (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .start(start), .pause(pause),
    .goal_p1(goal_p1), .goal_p2(goal_p2), .p1_score(p1_b), .p2_score(p2_b),
    .game_state(gs_b), .serve_side(side_b), .ball_en(ball_b));

  match_controller #(.SCORE_W(3), .WIN_SCORE(5), .WIN_BY_TWO(1), .SERVE_DELAY(1)) dut_c (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .start(start), .pause(pause),
    .goal_p1(goal_p1), .goal_p2(goal_p2), .p1_score(p1_c), .p2_score(p2_c),
    .game_state(gs_c), .serve_side(side_c), .ball_en(ball_c));

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_PAUSE = 3, S_P1W = 4, S_P2W = 5;

  typedef struct {int st; int p1; int p2; int side; int cnt; int from;} mdl_t;
  typedef struct {int win; int wbt; int sd; int maxv;} cfg_t;
  typedef struct packed {logic [2:0] st; logic [7:0] p1; logic [7:0] p2; logic side; logic ball;} obs_t;
  typedef struct {
    logic r; logic t; logic s; logic p; logic g1; logic g2;
    int st; int p1; int p2; int side; int ball;
  } vec_t;

  int   compared = 0;
  int   mismatched = 0;
  mdl_t mdl [3];
  cfg_t cfg [3];
  vec_t tbl [$];

  function automatic mdl_t reset_mdl();
    mdl_t m;
    m.st = S_IDLE; m.p1 = 0; m.p2 = 0; m.side = 0; m.cnt = 0; m.from = S_SERVE;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, cfg_t c, logic r, logic t, logic s, logic p,
                                 logic g1, logic g2);
    mdl_t n = m;
    int sc, op;
    bit won;
    if (r) return reset_mdl();
    if (m.st == S_IDLE || m.st == S_P1W || m.st == S_P2W) begin
      if (s) begin n.st = S_SERVE; n.p1 = 0; n.p2 = 0; n.side = 0; n.cnt = 0; end
    end else if (m.st == S_SERVE) begin
      if (p) begin n.st = S_PAUSE; n.from = S_SERVE; end
      else if (t) begin
        n.cnt = m.cnt + 1;
        if (n.cnt == c.sd) n.st = S_PLAY;
      end
    end else if (m.st == S_PLAY) begin
      if (p) begin n.st = S_PAUSE; n.from = S_PLAY; end
      else if (g1 && g2) begin n.st = S_SERVE; n.cnt = 0; end
      else if (g1 || g2) begin
        sc = g1 ? m.p1 : m.p2;
        op = g1 ? m.p2 : m.p1;
        if (sc == c.maxv) won = 1;
        else begin
          sc = sc + 1;
          won = (c.wbt != 0) ? (sc >= c.win && sc >= op + 2) : (sc == c.win);
        end
        if (g1) n.p1 = sc; else n.p2 = sc;
        n.side = g1 ? 1 : 0;
        n.cnt  = 0;
        n.st   = won ? (g1 ? S_P1W : S_P2W) : S_SERVE;
      end
    end else if (m.st == S_PAUSE) begin
      if (p) n.st = m.from;
    end
    return n;
  endfunction

  function automatic obs_t mk(int st, int p1, int p2, int side, int ball);
    obs_t o;
    o.st = 3'(st); o.p1 = 8'(p1); o.p2 = 8'(p2); o.side = 1'(side); o.ball = 1'(ball);
    return o;
  endfunction

  function automatic obs_t get(int i);
    if (i == 0) return mk(int'(gs_a), int'(p1_a), int'(p2_a), int'(side_a), int'(ball_a));
    if (i == 1) return mk(int'(gs_b), int'(p1_b), int'(p2_b), int'(side_b), int'(ball_b));
    return mk(int'(gs_c), int'(p1_c), int'(p2_c), int'(side_c), int'(ball_c));
  endfunction

  task automatic expect_obs(string nm, int i, obs_t e);
    obs_t g;
    g = get(i);
    compared++;
    if (g !== e) begin
      mismatched++;
      $display("FAIL %s dut%0d: got state=%0d p1=%0d p2=%0d side=%0d ball=%0d, expected state=%0d p1=%0d p2=%0d side=%0d ball=%0d",
               nm, i, g.st, g.p1, g.p2, g.side, g.ball, e.st, e.p1, e.p2, e.side, e.ball);
    end
  endtask

  task automatic step(logic r, logic t, logic s, logic p, logic g1, logic g2);
    reset = r; tick_1ms = t; start = s; pause = p; goal_p1 = g1; goal_p2 = g2;
    @(posedge clk);
    for (int i = 0; i < 3; i++) mdl[i] = mstep(mdl[i], cfg[i], r, t, s, p, g1, g2);
    #1;
    for (int i = 0; i < 3; i++)
      expect_obs("model", i, mk(mdl[i].st, mdl[i].p1, mdl[i].p2, mdl[i].side,
                                (mdl[i].st == S_PLAY) ? 1 : 0));
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    cfg[0] = '{win: 9, wbt: 0, sd: 3, maxv: 15};
    cfg[1] = '{win: 9, wbt: 1, sd: 5, maxv: 15};
    cfg[2] = '{win: 5, wbt: 1, sd: 1, maxv: 7};
    for (int i = 0; i < 3; i++) mdl[i] = reset_mdl();

    // fixed vectors for dut_a: r t s p g1 g2 | state p1 p2 side ball
    tbl.push_back('{1,0,0,0,0,0, 0,0,0,0,0});
    tbl.push_back('{0,0,1,0,0,0, 1,0,0,0,0});
    tbl.push_back('{0,1,0,0,0,0, 1,0,0,0,0});
    tbl.push_back('{0,1,0,0,0,0, 1,0,0,0,0});
    tbl.push_back('{0,1,0,0,0,0, 2,0,0,0,1});
    tbl.push_back('{0,0,0,0,1,0, 1,1,0,1,0});
    tbl.push_back('{0,0,0,0,0,1, 1,1,0,1,0});
    tbl.push_back('{0,1,0,0,0,0, 1,1,0,1,0});
    tbl.push_back('{0,1,0,0,0,0, 1,1,0,1,0});
    tbl.push_back('{0,1,0,0,0,0, 2,1,0,1,1});
    tbl.push_back('{0,0,0,0,1,1, 1,1,0,1,0});
    tbl.push_back('{0,0,0,1,0,0, 3,1,0,1,0});
    tbl.push_back('{0,1,0,0,0,0, 3,1,0,1,0});
    tbl.push_back('{0,1,0,0,1,0, 3,1,0,1,0});
    tbl.push_back('{0,0,0,1,0,0, 1,1,0,1,0});
    tbl.push_back('{0,0,1,0,0,0, 1,1,0,1,0});
    tbl.push_back('{0,1,0,0,0,0, 1,1,0,1,0});
    tbl.push_back('{0,1,0,0,0,0, 1,1,0,1,0});
    tbl.push_back('{0,1,0,0,0,0, 2,1,0,1,1});
    tbl.push_back('{0,0,0,1,0,0, 3,1,0,1,0});
    tbl.push_back('{0,0,0,1,0,0, 2,1,0,1,1});
    tbl.push_back('{0,0,0,0,0,1, 1,1,1,0,0});
    tbl.push_back('{1,0,1,1,0,0, 0,0,0,0,0});
    tbl.push_back('{0,0,1,1,0,0, 1,0,0,0,0});
    tbl.push_back('{0,0,0,1,0,0, 3,0,0,0,0});
    tbl.push_back('{0,0,0,1,0,0, 1,0,0,0,0});
    tbl.push_back('{0,0,0,1,1,0, 3,0,0,0,0});
    tbl.push_back('{1,0,0,0,0,0, 0,0,0,0,0});

    for (int v = 0; v < tbl.size(); v++) begin
      step(tbl[v].r, tbl[v].t, tbl[v].s, tbl[v].p, tbl[v].g1, tbl[v].g2);
      expect_obs($sformatf("vec%0d", v), 0,
                 mk(tbl[v].st, tbl[v].p1, tbl[v].p2, tbl[v].side, tbl[v].ball));
    end

    // reaching WIN_SCORE ends the match; later goals are ignored
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin ticks(3); step(0, 0, 0, 0, 1, 0); end
    ticks(3);
    expect_obs("play_at_8", 0, mk(2, 8, 0, 1, 1));
    step(0, 0, 0, 0, 1, 0);
    expect_obs("p1_wins", 0, mk(4, 9, 0, 1, 0));
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    ticks(3);
    expect_obs("win_holds", 0, mk(4, 9, 0, 1, 0));
    step(0, 0, 1, 0, 0, 0);
    expect_obs("restart_after_win", 0, mk(1, 0, 0, 0, 0));

    // win-by-two from 9-9
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      ticks(5); step(0, 0, 0, 0, 1, 0);
      ticks(5); step(0, 0, 0, 0, 0, 1);
    end
    expect_obs("tied_9_9", 1, mk(1, 9, 9, 0, 0));
    ticks(5); step(0, 0, 0, 0, 1, 0);
    expect_obs("lead_by_one", 1, mk(1, 10, 9, 1, 0));
    ticks(5); step(0, 0, 0, 0, 1, 0);
    expect_obs("lead_by_two", 1, mk(4, 11, 9, 1, 0));

    // pause preserves the serve countdown
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    ticks(2);
    step(0, 0, 0, 1, 0, 0);
    ticks(10);
    step(0, 0, 0, 1, 0, 0);
    expect_obs("resume_serve", 1, mk(1, 0, 0, 0, 0));
    ticks(2);
    expect_obs("count_4_of_5", 1, mk(1, 0, 0, 0, 0));
    ticks(1);
    expect_obs("count_5_of_5", 1, mk(2, 0, 0, 0, 1));

    // reset mid-pause at 5-3, then start beats pause
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      ticks(3);
      if (k < 5) step(0, 0, 0, 0, 1, 0); else step(0, 0, 0, 0, 0, 1);
    end
    step(0, 0, 0, 1, 0, 0);
    expect_obs("paused_5_3", 0, mk(3, 5, 3, 0, 0));
    step(1, 0, 0, 0, 0, 0);
    expect_obs("reset_in_pause", 0, mk(0, 0, 0, 0, 0));
    step(0, 0, 1, 1, 0, 0);
    expect_obs("start_over_pause", 0, mk(1, 0, 0, 0, 0));

    // score saturation at 2^SCORE_W-1 declares the scorer
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      ticks(1); step(0, 0, 0, 0, 1, 0);
      ticks(1); step(0, 0, 0, 0, 0, 1);
    end
    ticks(1); step(0, 0, 0, 0, 1, 0);
    expect_obs("sat_7_6", 2, mk(1, 7, 6, 1, 0));
    ticks(1); step(0, 0, 0, 0, 0, 1);
    expect_obs("sat_7_7", 2, mk(1, 7, 7, 0, 0));
    ticks(1); step(0, 0, 0, 0, 1, 0);
    expect_obs("sat_win", 2, mk(4, 7, 7, 1, 0));

    // random traffic against the model
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter SCORE_W, default 4, width of each score counter.
REQ-002 Parameter WIN_SCORE, default 9, goals needed to win; SHALL be at most 2^SCORE_W-1.
REQ-003 Parameter WIN_BY_TWO, default 0; 1 adds a 2-goal lead requirement to the win rule.
REQ-004 Parameter SERVE_DELAY, default 1000, number of tick_1ms pulses spent in SERVE; SHALL be at least 1.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 tick_1ms  input  1  one-cycle strobe, one per millisecond.
REQ-008 start  input  1  one-cycle pulse: begin a new match.
REQ-009 pause  input  1  one-cycle pulse: toggle pause.
REQ-010 goal_p1  input  1  one-cycle pulse: P1 scored.
REQ-011 goal_p2  input  1  one-cycle pulse: P2 scored.
REQ-012 p1_score  output  SCORE_W  registered P1 score.
REQ-013 p2_score  output  SCORE_W  registered P2 score.
REQ-014 game_state  output  3  encoding: IDLE=000, SERVE=001, PLAY=010, PAUSE=011, P1_WIN=100, P2_WIN=101.
REQ-015 serve_side  output  1  serving player: 0=P1, 1=P2.
REQ-016 ball_en  output  1  high only in PLAY; ball logic moves only when high.

Function
REQ-017 All outputs SHALL be registered; every input event takes effect on the first rising edge after it is sampled, with 1-cycle latency.
REQ-018 IDLE: start moves the block to SERVE, clears both scores and sets serve_side=0.
REQ-019 P1_WIN or P2_WIN: start behaves as in IDLE; all other inputs are ignored and the scores hold.
REQ-020 SERVE: an internal delay counter, cleared on entry, increments on each tick_1ms. On the tick that brings the count to SERVE_DELAY, the block moves to PLAY.
REQ-021 PLAY, exactly one goal pulse:
  - the scorer's score increments by 1;
  - serve_side becomes the conceding player;
  - the block moves to SERVE, or to the scorer's WIN state if the win rule is met by the new score.
REQ-022 PLAY, goal_p1 and goal_p2 both high in the same cycle: no score change, serve_side unchanged, move to SERVE.
REQ-023 Win rule, WIN_BY_TWO=0: the new score equals WIN_SCORE.
REQ-024 Win rule, WIN_BY_TWO=1: the new score is at least WIN_SCORE and at least 2 above the opponent's score.
REQ-025 WIN_BY_TWO=1 saturation: an increment that would exceed 2^SCORE_W-1 leaves the score at its maximum and declares the scorer the winner.
REQ-026 Goal pulses outside PLAY SHALL be ignored.
REQ-027 pause in SERVE or PLAY moves to PAUSE and records the state it came from.
REQ-028 In PAUSE, the delay counter freezes and tick_1ms and goal pulses are ignored; a second pause returns to the recorded state with the counter value preserved.
REQ-029 pause in IDLE or either WIN state SHALL be ignored.
REQ-030 start has priority over pause in the same cycle. In SERVE, PLAY or PAUSE, start SHALL be ignored.
REQ-031 The win check SHALL use the next score value, not the registered one, so that the WIN state and the final score appear in the same cycle.
REQ-032 Unused state encodings SHALL return to IDLE on the next edge.

Reset
REQ-033 While reset is high at a clock edge, the block SHALL set: game_state=IDLE, p1_score=0, p2_score=0, serve_side=0, ball_en=0, delay counter=0, recorded pause state=SERVE.
REQ-034 Reset SHALL override every other input, in any state, including a reset asserted mid-match or mid-pause.

Verification
REQ-035 Reset, start, then 3 ticks with SERVE_DELAY=3 -> state 001 for the 3 ticks, 010 on the edge after the 3rd tick, ball_en=1.
REQ-036 PLAY with p1_score=8 and WIN_SCORE=9, goal_p1 pulse -> next cycle p1_score=9, game_state=100, ball_en=0; further goal pulses leave the scores at 9/p2.
REQ-037 WIN_BY_TWO=1 at 9-9: goal_p1 -> 10-9, state SERVE, serve_side=1; goal_p1 again -> 11-9, state 100.
REQ-038 SERVE with delay count 2 of 5, pause, 10 ticks, pause -> back in SERVE with count 2; exactly 3 more ticks reach PLAY.
REQ-039 PLAY with goal_p1 and goal_p2 in the same cycle -> scores unchanged, SERVE, serve_side unchanged; a goal pulse while in SERVE -> no score change.
REQ-040 Reset pulse while in PAUSE at 5-3 -> next cycle IDLE, 0-0, serve_side=0; start then pause in the same cycle -> SERVE, not PAUSE.
